// File: rtl/grid_pkg.sv
// -----------------------------------------------------------------------------
// grid_pkg
// Shared definitions for the 64x48 GridData tile RAM write path.
//   - Grid geometry, address and color widths, read-B latency
//   - Command op encodings (grid_op_e)
//   - grid_writer FSM state encoding (grid_state_e)
//   - COLOR_EMPTY: the color index of an unoccupied cell
// -----------------------------------------------------------------------------
package grid_pkg;

    localparam int GRID_W     = 64;    // columns, power of two
    localparam int GRID_H     = 48;    // rows
    localparam int ADDR_W     = 12;    // GridData address width
    localparam int COLOR_W    = 4;     // color index width
    localparam int RD_LAT     = 2;     // address-to-qb latency of read port B
    localparam int COORD_W    = 6;     // width of the x/y command fields
    localparam int GRID_CELLS = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        OP_PLOT  = 2'b00,
        OP_PROBE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } grid_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_RESP    = 3'd4
    } grid_state_e;

    localparam logic [COLOR_W-1:0] COLOR_EMPTY = '0;

endpackage

// File: rtl/grid_addr_gen.sv
// -----------------------------------------------------------------------------
// grid_addr_gen
// Combinational coordinate-to-address packing plus range check for the tile
// grid. Shared by every block that writes GridData.
//   x, y  : cell coordinates (COORD_W bits each)
//   addr  : y*GRID_W + x, zero-extended to ADDR_W
//   oob   : coordinate outside the GRID_W x GRID_H grid
// -----------------------------------------------------------------------------
module grid_addr_gen #(
    parameter int GRID_W  = grid_pkg::GRID_W,
    parameter int GRID_H  = grid_pkg::GRID_H,
    parameter int ADDR_W  = grid_pkg::ADDR_W,
    parameter int COORD_W = grid_pkg::COORD_W
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               oob
);

    // GRID_W is a power of two, so the multiply collapses to a shift.
    localparam int XB = $clog2(GRID_W);
    // GRID_H must stay below 2**COORD_W for this limit to be meaningful.
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(GRID_H);

    logic x_oob;

    generate
        if (XB < COORD_W) begin : g_xchk
            assign x_oob = |x[COORD_W-1:XB];
        end else begin : g_xfull
            // Every encodable x is a valid column.
            assign x_oob = 1'b0;
        end
    endgenerate

    assign addr = (ADDR_W'(y) << XB) | ADDR_W'(x);
    assign oob  = x_oob | (y >= Y_LIM);

endmodule

// File: rtl/grid_writer.sv
// -----------------------------------------------------------------------------
// grid_writer
// Command-driven write engine for the GridData tile RAM. Turns PLOT,
// PROBE_PLOT (read-then-write collision check), READ and full-screen CLEAR
// commands into sequenced RAM accesses and returns a one-cycle response.
//
// Ports
//   clock_in, iRST_n       clock / asynchronous active-low reset
//   cmd_valid, cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/x/y/color       command fields, latched on acceptance
//   wren_gridData          RAM write enable
//   wraddress_gridData     RAM write address, shared with the read-B address
//   data_gridData          RAM write data
//   color_data_in          RAM read-B data, valid RD_LAT cycles after address
//   rsp_valid              one-cycle response strobe
//   rsp_color/hit/err      response fields, held until the next response
// -----------------------------------------------------------------------------
module grid_writer #(
    parameter int GRID_W  = grid_pkg::GRID_W,
    parameter int GRID_H  = grid_pkg::GRID_H,
    parameter int ADDR_W  = grid_pkg::ADDR_W,
    parameter int COLOR_W = grid_pkg::COLOR_W,
    parameter int RD_LAT  = grid_pkg::RD_LAT
) (
    input  logic               clock_in,
    input  logic               iRST_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_x,
    input  logic [5:0]         cmd_y,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               wren_gridData,
    output logic [ADDR_W-1:0]  wraddress_gridData,
    output logic [COLOR_W-1:0] data_gridData,
    input  logic [COLOR_W-1:0] color_data_in,
    output logic               rsp_valid,
    output logic [COLOR_W-1:0] rsp_color,
    output logic               rsp_hit,
    output logic               rsp_err
);

    import grid_pkg::*;

    // rd_cnt counts 0 .. RD_LAT-1 while the read address settles.
    localparam int RD_CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
    localparam logic [RD_CNT_W-1:0] RD_LAST  = RD_CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0]   CLR_LAST = ADDR_W'(GRID_W * GRID_H - 1);

    grid_state_e           state_q,     state_d;
    grid_op_e              op_q,        op_d;
    logic [COLOR_W-1:0]    color_q,     color_d;
    logic [COLOR_W-1:0]    cap_q,       cap_d;
    logic [RD_CNT_W-1:0]   rd_cnt_q,    rd_cnt_d;
    logic [ADDR_W-1:0]     clr_cnt_q,   clr_cnt_d;
    logic                  wren_q,      wren_d;
    logic [ADDR_W-1:0]     waddr_q,     waddr_d;
    logic [COLOR_W-1:0]    wdata_q,     wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [COLOR_W-1:0]    rsp_color_q, rsp_color_d;
    logic                  rsp_hit_q,   rsp_hit_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic [ADDR_W-1:0]     cmd_addr;
    logic                  cmd_oob;

    grid_addr_gen #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .ADDR_W  (ADDR_W),
        .COORD_W (6)
    ) u_addr_gen (
        .x    (cmd_x),
        .y    (cmd_y),
        .addr (cmd_addr),
        .oob  (cmd_oob)
    );

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. Every RAM-facing output is registered,
    // so each value below takes effect in the cycle after the deciding edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch; blocking '=' is correct here.
        state_d     = state_q;
        op_d        = op_q;
        color_d     = color_q;
        cap_d       = cap_q;
        rd_cnt_d    = rd_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        wren_d      = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_color_d = rsp_color_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = grid_op_e'(cmd_op);
                    color_d = cmd_color;
                    if (grid_op_e'(cmd_op) == OP_CLEAR) begin
                        // First clear write goes out right away at address 0.
                        state_d   = ST_CLEAR;
                        clr_cnt_d = '0;
                        wren_d    = 1'b1;
                        waddr_d   = '0;
                        wdata_d   = cmd_color;
                    end else if (cmd_oob) begin
                        // Bad coordinate: answer immediately, never touch RAM.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_color_d = COLOR_EMPTY;
                        rsp_hit_d   = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else if (grid_op_e'(cmd_op) == OP_PLOT) begin
                        state_d = ST_WRITE;
                        wren_d  = 1'b1;
                        waddr_d = cmd_addr;
                        wdata_d = cmd_color;
                    end else begin
                        // PROBE and READ: present the read-B address first.
                        state_d  = ST_RD_WAIT;
                        rd_cnt_d = '0;
                        waddr_d  = cmd_addr;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (rd_cnt_q == RD_LAST) begin
                    cap_d = color_data_in;
                    if (op_q == OP_PROBE) begin
                        // Write happens regardless of whether the cell was hit;
                        // the address is still held from acceptance.
                        state_d = ST_WRITE;
                        wren_d  = 1'b1;
                        wdata_d = color_q;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_color_d = color_data_in;
                        rsp_hit_d   = 1'b0;
                        rsp_err_d   = 1'b0;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end

            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                if (op_q == OP_PROBE) begin
                    rsp_color_d = cap_q;
                    rsp_hit_d   = (cap_q != COLOR_EMPTY);
                end else begin
                    rsp_color_d = COLOR_EMPTY;
                    rsp_hit_d   = 1'b0;
                end
            end

            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_color_d = COLOR_EMPTY;
                    rsp_hit_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    wren_d    = 1'b1;
                    waddr_d   = clr_cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset aborts any command mid-flight; a
    // partially cleared grid is simply left as-is in RAM.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PLOT;
            color_q     <= '0;
            cap_q       <= '0;
            rd_cnt_q    <= '0;
            clr_cnt_q   <= '0;
            wren_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_color_q <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking '<=' so every register samples pre-edge values.
            state_q     <= state_d;
            op_q        <= op_d;
            color_q     <= color_d;
            cap_q       <= cap_d;
            rd_cnt_q    <= rd_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            wren_q      <= wren_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_color_q <= rsp_color_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready          = (state_q == ST_IDLE);
    assign wren_gridData      = wren_q;
    assign wraddress_gridData = waddr_q;
    assign data_gridData      = wdata_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_color          = rsp_color_q;
    assign rsp_hit            = rsp_hit_q;
    assign rsp_err            = rsp_err_q;

endmodule

// File: tb/tb_grid_writer.sv
// -----------------------------------------------------------------------------
// tb_grid_writer
// Self-checking bench for grid_writer: directed vector table, hand-written
// multi-cycle sequences (reset mid-clear, clear with a held command) and
// randomized commands checked against a behavioural grid model. Includes a
// GridData RAM model whose read-B data is valid RD_LAT cycles after the
// address is presented.
// -----------------------------------------------------------------------------
module tb_grid_writer;

    import grid_pkg::*;

    localparam int RAM_DEPTH = 1 << ADDR_W;

    logic               clock_in = 1'b0;
    logic               iRST_n   = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op    = 2'b00;
    logic [5:0]         cmd_x     = '0;
    logic [5:0]         cmd_y     = '0;
    logic [COLOR_W-1:0] cmd_color = '0;
    logic               wren_gridData;
    logic [ADDR_W-1:0]  wraddress_gridData;
    logic [COLOR_W-1:0] data_gridData;
    logic [COLOR_W-1:0] color_data_in;
    logic               rsp_valid;
    logic [COLOR_W-1:0] rsp_color;
    logic               rsp_hit;
    logic               rsp_err;

    grid_writer dut (
        .clock_in           (clock_in),
        .iRST_n             (iRST_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_x              (cmd_x),
        .cmd_y              (cmd_y),
        .cmd_color          (cmd_color),
        .wren_gridData      (wren_gridData),
        .wraddress_gridData (wraddress_gridData),
        .data_gridData      (data_gridData),
        .color_data_in      (color_data_in),
        .rsp_valid          (rsp_valid),
        .rsp_color          (rsp_color),
        .rsp_hit            (rsp_hit),
        .rsp_err            (rsp_err)
    );

    always #5 clock_in = ~clock_in;

    // ---------------- GridData RAM model ----------------
    logic [COLOR_W-1:0] mem [RAM_DEPTH];
    logic               mem_init = 1'b1;
    logic [ADDR_W-1:0]  rd_addr_r;

    always @(posedge clock_in) begin
        if (mem_init) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= '0;
        end else if (wren_gridData) begin
            mem[wraddress_gridData] <= data_gridData;
        end
        rd_addr_r <= wraddress_gridData;
    end
    assign color_data_in = mem[rd_addr_r];

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observed writes of the current command (address, data, relative cycle).
    int wr_a[$];
    int wr_d[$];
    int wr_c[$];
    // Expected writes from the reference model.
    int exp_wa[$];
    int exp_wd[$];
    int exp_wc[$];

    // ---------------- behavioural reference model ----------------
    logic [COLOR_W-1:0] grid [RAM_DEPTH];

    typedef struct {
        int                 cyc;
        logic [COLOR_W-1:0] color;
        logic               hit;
        logic               err;
    } exp_t;

    function automatic exp_t model_cmd(input logic [1:0] op, input int x, input int y,
                                       input logic [COLOR_W-1:0] col);
        exp_t e;
        int   a;
        e.cyc = 0; e.color = '0; e.hit = 1'b0; e.err = 1'b0;
        exp_wa.delete(); exp_wd.delete(); exp_wc.delete();
        a = y * GRID_W + x;
        if (op != OP_CLEAR && (x >= GRID_W || y >= GRID_H)) begin
            e.err = 1'b1;
            e.cyc = 1;
        end else if (op == OP_PLOT) begin
            exp_wa.push_back(a); exp_wd.push_back(int'(col)); exp_wc.push_back(1);
            grid[a] = col;
            e.cyc = 2;
        end else if (op == OP_PROBE) begin
            e.color = grid[a];
            e.hit   = (grid[a] != 0);
            exp_wa.push_back(a); exp_wd.push_back(int'(col)); exp_wc.push_back(RD_LAT + 1);
            grid[a] = col;
            e.cyc = RD_LAT + 2;
        end else if (op == OP_READ) begin
            e.color = grid[a];
            e.cyc   = RD_LAT + 1;
        end else begin
            for (int i = 0; i < GRID_CELLS; i++) begin
                exp_wa.push_back(i); exp_wd.push_back(int'(col)); exp_wc.push_back(i + 1);
                grid[i] = col;
            end
            e.cyc = GRID_CELLS + 1;
        end
        return e;
    endfunction

    function automatic int write_mism();
        int m = 0;
        if (wr_a.size() != exp_wa.size()) m++;
        for (int i = 0; i < wr_a.size() && i < exp_wa.size(); i++)
            if (wr_a[i] != exp_wa[i] || wr_d[i] != exp_wd[i] || wr_c[i] != exp_wc[i]) m++;
        return m;
    endfunction

    // ---------------- command driver ----------------
    typedef struct {
        int                 cyc;
        logic [COLOR_W-1:0] color;
        logic               hit;
        logic               err;
        int                 ready_err;
        logic               ready_after;
        logic               valid_after;
    } res_t;

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                           input logic [COLOR_W-1:0] col, input bit noise, output res_t r);
        int  n;
        int  rel;
        bit  got;
        r.cyc = -1; r.color = '0; r.hit = 1'b0; r.err = 1'b0;
        r.ready_err = 0; r.ready_after = 1'b0; r.valid_after = 1'b1;
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        @(negedge clock_in);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = col; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clock_in);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clock_in);          // cycle 1 relative to the acceptance edge
        cmd_valid = 1'b0;
        rel = 1;
        got = 1'b0;
        while (!got && rel <= GRID_CELLS + 100) begin
            if (wren_gridData) begin
                wr_a.push_back(int'(wraddress_gridData));
                wr_d.push_back(int'(data_gridData));
                wr_c.push_back(rel);
            end
            if (cmd_ready) r.ready_err++;
            if (rsp_valid) begin
                got = 1'b1;
                r.cyc = rel; r.color = rsp_color; r.hit = rsp_hit; r.err = rsp_err;
                cmd_valid = 1'b0;
            end else begin
                // Scribble on the command bus while busy: must be ignored.
                cmd_op = 2'($urandom); cmd_x = 6'($urandom); cmd_y = 6'($urandom);
                cmd_color = COLOR_W'($urandom);
                cmd_valid = noise ? 1'($urandom) : 1'b0;
                @(negedge clock_in);
                rel++;
            end
        end
        cmd_valid = 1'b0;
        if (!got) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        @(negedge clock_in);
        if (wren_gridData) begin
            wr_a.push_back(int'(wraddress_gridData));
            wr_d.push_back(int'(data_gridData));
            wr_c.push_back(rel + 1);
        end
        r.ready_after = cmd_ready;
        r.valid_after = rsp_valid;
    endtask

    task automatic check_handshake(input string tag, input res_t r);
        check({tag, "_busy_ready"}, 32'(r.ready_err), 32'd0);
        check({tag, "_ready_after"}, 32'(r.ready_after), 32'd1);
        check({tag, "_one_cycle_rsp"}, 32'(r.valid_after), 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]         op;
        logic [5:0]         x;
        logic [5:0]         y;
        logic [COLOR_W-1:0] col;
        int                 e_cyc;
        logic [COLOR_W-1:0] e_color;
        logic               e_hit;
        logic               e_err;
        int                 e_nwr;
        int                 e_wa;
        logic [COLOR_W-1:0] e_wd;
        int                 e_wc;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input int x, input int y, input int col,
                                input int e_cyc, input int e_color, input int e_hit,
                                input int e_err, input int e_nwr, input int e_wa,
                                input int e_wd, input int e_wc);
        vec_t v;
        v.op = op; v.x = 6'(x); v.y = 6'(y); v.col = COLOR_W'(col);
        v.e_cyc = e_cyc; v.e_color = COLOR_W'(e_color); v.e_hit = 1'(e_hit);
        v.e_err = 1'(e_err); v.e_nwr = e_nwr; v.e_wa = e_wa; v.e_wd = COLOR_W'(e_wd);
        v.e_wc = e_wc;
        return v;
    endfunction

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    initial begin
        res_t  r;
        exp_t  e;
        string tag;
        int    n;
        int    order_err;
        int    rsp_rel;
        int    ready_rel;
        int    plot_rel;
        int    plot_addr;
        int    plot_data;
        int    nrsp;
        int    nclear;
        int    m;

        for (int i = 0; i < RAM_DEPTH; i++) grid[i] = '0;

        //            op        x   y  col  cyc col hit err nwr  addr  wd wc
        vecs[0]  = mk(OP_PLOT,  10, 10, 7,   2,  0,  0,  0,  1,  650,  7, 1);
        vecs[1]  = mk(OP_PLOT,   5,  3, 4,   2,  0,  0,  0,  1,  197,  4, 1);
        vecs[2]  = mk(OP_PROBE, 10, 10, 2,   4,  7,  1,  0,  1,  650,  2, 3);
        vecs[3]  = mk(OP_PROBE, 20,  1, 3,   4,  0,  0,  0,  1,   84,  3, 3);
        vecs[4]  = mk(OP_PLOT,  63, 47, 9,   2,  0,  0,  0,  1, 3071,  9, 1);
        vecs[5]  = mk(OP_PLOT,   0,  0, 1,   2,  0,  0,  0,  1,    0,  1, 1);
        vecs[6]  = mk(OP_READ,  63, 47, 0,   3,  9,  0,  0,  0,    0,  0, 0);
        vecs[7]  = mk(OP_PLOT,   0, 48, 5,   1,  0,  0,  1,  0,    0,  0, 0);
        vecs[8]  = mk(OP_PROBE,  1, 63, 6,   1,  0,  0,  1,  0,    0,  0, 0);
        vecs[9]  = mk(OP_READ,   5,  3, 0,   3,  4,  0,  0,  0,    0,  0, 0);
        vecs[10] = mk(OP_PROBE,  5,  3, 0,   4,  4,  1,  0,  1,  197,  0, 3);
        vecs[11] = mk(OP_READ,   5,  3, 0,   3,  0,  0,  0,  0,    0,  0, 0);
        vecs[12] = mk(OP_READ,  10, 10, 0,   3,  2,  0,  0,  0,    0,  0, 0);
        vecs[13] = mk(OP_READ,  63, 47, 0,   3,  9,  0,  0,  0,    0,  0, 0);

        // ---- reset state ----
        repeat (3) @(negedge clock_in);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wren", 32'(wren_gridData), 32'd0);
        check("rst_wraddr", 32'(wraddress_gridData), 32'd0);
        check("rst_data", 32'(data_gridData), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_color", 32'(rsp_color), 32'd0);
        check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        iRST_n   = 1'b1;
        mem_init = 1'b0;
        repeat (2) @(negedge clock_in);

        // ---- directed table ----
        for (int i = 0; i < NVEC; i++) begin
            e = model_cmd(vecs[i].op, int'(vecs[i].x), int'(vecs[i].y), vecs[i].col);
            run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].col, 1'b0, r);
            tag = $sformatf("vec%0d", i);
            check({tag, "_rsp_cycle"}, 32'(r.cyc), 32'(vecs[i].e_cyc));
            check({tag, "_rsp_color"}, 32'(r.color), 32'(vecs[i].e_color));
            check({tag, "_rsp_hit"}, 32'(r.hit), 32'(vecs[i].e_hit));
            check({tag, "_rsp_err"}, 32'(r.err), 32'(vecs[i].e_err));
            check({tag, "_num_writes"}, 32'(wr_a.size()), 32'(vecs[i].e_nwr));
            if (vecs[i].e_nwr == 1) begin
                check({tag, "_wr_addr"}, 32'(wr_a.size() > 0 ? wr_a[0] : -1), 32'(vecs[i].e_wa));
                check({tag, "_wr_data"}, 32'(wr_d.size() > 0 ? wr_d[0] : -1), 32'(vecs[i].e_wd));
                check({tag, "_wr_cycle"}, 32'(wr_c.size() > 0 ? wr_c[0] : -1), 32'(vecs[i].e_wc));
            end
            check_handshake(tag, r);
        end

        // ---- reset in the middle of a CLEAR (rsp_color currently 9) ----
        @(negedge clock_in);
        cmd_op = OP_CLEAR; cmd_color = 4'd5; cmd_valid = 1'b1;
        @(negedge clock_in);          // cycle 1
        cmd_valid = 1'b0;
        n = 0;
        for (int rel = 1; rel < 100; rel++) begin
            if (wren_gridData) n++;
            @(negedge clock_in);
        end
        if (wren_gridData) n++;       // cycle 100: write of address 99 pending
        iRST_n = 1'b0;
        #1;
        check("midclr_pulses_before_rst", 32'(n), 32'd100);
        check("midclr_wren", 32'(wren_gridData), 32'd0);
        check("midclr_wraddr", 32'(wraddress_gridData), 32'd0);
        check("midclr_data", 32'(data_gridData), 32'd0);
        check("midclr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midclr_rsp_color", 32'(rsp_color), 32'd0);
        check("midclr_rsp_hit", 32'(rsp_hit), 32'd0);
        check("midclr_rsp_err", 32'(rsp_err), 32'd0);
        check("midclr_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 99; i++) grid[i] = 4'd5;
        @(negedge clock_in);
        iRST_n = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_in);
            if (wren_gridData) n++;
        end
        check("midclr_no_writes_after", 32'(n), 32'd0);

        // ---- CLEAR color 0 with a PLOT held on cmd_valid throughout ----
        @(negedge clock_in);
        cmd_op = OP_CLEAR; cmd_x = '0; cmd_y = '0; cmd_color = '0; cmd_valid = 1'b1;
        @(negedge clock_in);          // cycle 1
        cmd_op = OP_PLOT; cmd_x = 6'd1; cmd_y = 6'd1; cmd_color = 4'd6;
        nclear = 0; order_err = 0; rsp_rel = -1; ready_rel = -1;
        plot_rel = -1; plot_addr = -1; plot_data = -1; nrsp = 0;
        for (int rel = 1; rel <= GRID_CELLS + 8; rel++) begin
            if (cmd_ready && ready_rel < 0) ready_rel = rel;
            if (wren_gridData) begin
                if (ready_rel < 0) begin
                    if (int'(wraddress_gridData) != nclear || data_gridData != 0) order_err++;
                    nclear++;
                end else if (plot_rel < 0) begin
                    plot_rel  = rel;
                    plot_addr = int'(wraddress_gridData);
                    plot_data = int'(data_gridData);
                    cmd_valid = 1'b0;
                end else begin
                    order_err++;
                end
            end
            if (rsp_valid) begin
                nrsp++;
                if (rsp_rel < 0) rsp_rel = rel;
            end
            @(negedge clock_in);
        end
        cmd_valid = 1'b0;
        check("clr_num_writes", 32'(nclear), 32'(GRID_CELLS));
        check("clr_order_errors", 32'(order_err), 32'd0);
        check("clr_rsp_cycle", 32'(rsp_rel), 32'(GRID_CELLS + 1));
        check("clr_ready_cycle", 32'(ready_rel), 32'(GRID_CELLS + 2));
        check("held_plot_cycle", 32'(plot_rel), 32'(GRID_CELLS + 3));
        check("held_plot_addr", 32'(plot_addr), 32'd65);
        check("held_plot_data", 32'(plot_data), 32'd6);
        check("clr_rsp_count", 32'(nrsp), 32'd2);
        for (int i = 0; i < GRID_CELLS; i++) grid[i] = '0;
        grid[65] = 4'd6;

        // ---- randomized commands vs. model ----
        n = 0;
        for (int i = 0; i < 60; i++) begin
            logic [1:0]         op;
            logic [5:0]         x;
            logic [5:0]         y;
            logic [COLOR_W-1:0] col;
            int                 pick;
            pick = $urandom_range(0, 29);
            if (pick == 0 && n < 2) begin
                op = OP_CLEAR;
                n++;
            end else begin
                case (pick % 3)
                    0:       op = OP_PLOT;
                    1:       op = OP_PROBE;
                    default: op = OP_READ;
                endcase
            end
            x   = 6'($urandom_range(0, 63));
            y   = 6'($urandom_range(0, 55));
            col = COLOR_W'($urandom);
            e = model_cmd(op, int'(x), int'(y), col);
            run_cmd(op, x, y, col, 1'b1, r);
            tag = $sformatf("rnd%0d", i);
            check({tag, "_rsp_cycle"}, 32'(r.cyc), 32'(e.cyc));
            check({tag, "_rsp_color"}, 32'(r.color), 32'(e.color));
            check({tag, "_rsp_hit"}, 32'(r.hit), 32'(e.hit));
            check({tag, "_rsp_err"}, 32'(r.err), 32'(e.err));
            check({tag, "_writes"}, 32'(write_mism()), 32'd0);
            check_handshake(tag, r);
        end

        // ---- final RAM image vs. model ----
        repeat (2) @(negedge clock_in);
        m = 0;
        for (int i = 0; i < RAM_DEPTH; i++) if (mem[i] !== grid[i]) m++;
        check("ram_image_mismatches", 32'(m), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
